// File: rtl/spi_flash_op_sequencer.sv
// Expands one high-level flash op (read/program/erase/status) into the SPI engine's
// descriptor sequence: optional WREN, main command, then status polling until WIP clears.
module spi_flash_op_sequencer #(
  parameter logic [1:0]  ADDR_BYTES = 2'd2,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [15:0] POLL_LIMIT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_address,
  input  logic [7:0]  op_length,
  output logic        op_done,
  output logic        op_error,
  output logic [7:0]  op_status,
  output logic        access_request,
  output logic        read_write_n,
  output logic [2:0]  dummy_cycles,
  output logic        dummy_valid,
  output logic [31:0] address,
  output logic [1:0]  address_bytes,
  output logic        address_valid,
  output logic [7:0]  command,
  output logic [7:0]  data_bytes,
  output logic        data_valid,
  input  logic        access_complete,
  input  logic        rdb_write_enable,
  input  logic [7:0]  rdb_write_address,
  input  logic [7:0]  rdb_write_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WREN_WAIT, S_MAIN, S_MAIN_WAIT,
    S_POLL, S_POLL_WAIT, S_CHECK, S_DONE
  } state_t;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_PROGRAM = 2'b01;
  localparam logic [1:0] OP_STATUS  = 2'b11;

  state_t      r_state;
  logic [1:0]  r_code;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [15:0] r_poll_cnt;
  logic [15:0] w_cnt_inc;

  // Saturating increment so a huge POLL_LIMIT can never wrap the counter.
  assign w_cnt_inc    = (r_poll_cnt == 16'hFFFF) ? r_poll_cnt : r_poll_cnt + 16'd1;
  assign op_ready     = (r_state == S_IDLE);
  assign dummy_cycles = 3'd0;
  assign dummy_valid  = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_code         <= 2'b00;
      r_addr         <= 32'd0;
      r_len          <= 8'd0;
      r_poll_cnt     <= 16'd0;
      op_done        <= 1'b0;
      op_error       <= 1'b0;
      op_status      <= 8'd0;
      access_request <= 1'b0;
      read_write_n   <= 1'b0;
      address        <= 32'd0;
      address_bytes  <= 2'd0;
      address_valid  <= 1'b0;
      command        <= 8'd0;
      data_bytes     <= 8'd0;
      data_valid     <= 1'b0;
    end else begin
      op_done <= 1'b0;
      if (r_state == S_POLL_WAIT && rdb_write_enable && rdb_write_address == 8'd0)
        op_status <= rdb_write_data;
      case (r_state)
        S_IDLE: begin
          if (op_valid) begin
            r_code     <= op_code;
            r_addr     <= op_address;
            r_len      <= op_length;
            r_poll_cnt <= 16'd0;
            op_error   <= 1'b0;
            case (op_code)
              OP_READ:   r_state <= S_MAIN;
              OP_STATUS: r_state <= S_POLL;
              default:   r_state <= S_WREN;
            endcase
          end
        end
        S_WREN: begin
          access_request <= 1'b1;
          command        <= 8'h06;
          read_write_n   <= 1'b0;
          address        <= 32'd0;
          address_bytes  <= 2'd0;
          address_valid  <= 1'b0;
          data_bytes     <= 8'd0;
          data_valid     <= 1'b0;
          r_state        <= S_WREN_WAIT;
        end
        S_WREN_WAIT: begin
          if (access_complete) begin
            access_request <= 1'b0;
            r_state        <= S_MAIN;
          end
        end
        S_MAIN: begin
          access_request <= 1'b1;
          address        <= r_addr;
          address_bytes  <= ADDR_BYTES;
          address_valid  <= 1'b1;
          if (r_code == OP_READ) begin
            command      <= READ_CMD;
            read_write_n <= 1'b1;
            data_bytes   <= r_len;
            data_valid   <= 1'b1;
          end else if (r_code == OP_PROGRAM) begin
            command      <= 8'h02;
            read_write_n <= 1'b0;
            data_bytes   <= r_len;
            data_valid   <= 1'b1;
          end else begin
            command      <= 8'h20;
            read_write_n <= 1'b0;
            data_bytes   <= 8'd0;
            data_valid   <= 1'b0;
          end
          r_state <= S_MAIN_WAIT;
        end
        S_MAIN_WAIT: begin
          if (access_complete) begin
            access_request <= 1'b0;
            if (r_code == OP_READ) begin
              op_done  <= 1'b1;
              op_error <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_POLL;
            end
          end
        end
        S_POLL: begin
          access_request <= 1'b1;
          command        <= 8'h05;
          read_write_n   <= 1'b1;
          address        <= 32'd0;
          address_bytes  <= 2'd0;
          address_valid  <= 1'b0;
          data_bytes     <= 8'd0;
          data_valid     <= 1'b1;
          r_state        <= S_POLL_WAIT;
        end
        S_POLL_WAIT: begin
          if (access_complete) begin
            access_request <= 1'b0;
            if (r_code == OP_STATUS) begin
              op_done  <= 1'b1;
              op_error <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (!op_status[0]) begin
            op_done  <= 1'b1;
            op_error <= 1'b0;
            r_state  <= S_DONE;
          end else begin
            r_poll_cnt <= w_cnt_inc;
            if (w_cnt_inc == POLL_LIMIT) begin
              op_done  <= 1'b1;
              op_error <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_POLL;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
